// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG 1149.1 host: command-driven TMS/TDI sequencer with TDO capture
// Walks one TAP through reset, IR/DR scans and run-idle while shadowing whether it sits in TLR or RTI.
module jtag_host #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              tclk,
  input  logic              trst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tap_tms,
  output logic              tap_tdi,
  input  logic              tap_tdo
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(5);
  localparam logic [1:0]       OP_RESET = 2'd0;
  localparam logic [1:0]       OP_IR    = 2'd1;
  localparam logic [1:0]       OP_IDLE  = 2'd3;

  typedef enum logic [2:0] {
    H_IDLE,
    H_RESET,
    H_PRE,
    H_LEAD,
    H_SHIFT,
    H_TAIL,
    H_RUN
  } h_state_t;

  h_state_t          r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_op, w_op_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_rti, w_rti_nxt;
  logic [DATA_W-1:0] r_cap;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_tms, r_tdi;
  logic              w_accept, w_done;
  logic              w_tms_nxt, w_tdi_nxt;
  logic [LEN_W-1:0]  w_len_clamp, w_lead_last;

  assign cmd_ready = (r_state == H_IDLE) && !r_rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state != H_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign tap_tms   = r_tms;
  assign tap_tdi   = r_tdi;

  assign w_len_clamp = (cmd_len == '0)     ? LEN_ONE :
                       (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  // IR path needs the extra Select-IR step, hence one more lead cycle.
  assign w_lead_last = (r_op == OP_IR) ? LEN_W'(3) : LEN_W'(2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_rti_nxt   = r_rti;
    w_done      = 1'b0;
    case (r_state)
      H_IDLE: begin
        if (w_accept) begin
          w_op_nxt   = cmd_op;
          w_len_nxt  = w_len_clamp;
          w_data_nxt = cmd_data;
          w_cnt_nxt  = '0;
          if (cmd_op == OP_RESET)
            w_state_nxt = H_RESET;
          else if (!r_rti)
            w_state_nxt = H_PRE;
          else
            w_state_nxt = (cmd_op == OP_IDLE) ? H_RUN : H_LEAD;
        end
      end
      H_RESET: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = H_IDLE;
          w_rti_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LEN_ONE;
        end
      end
      H_PRE: begin
        w_state_nxt = (r_op == OP_IDLE) ? H_RUN : H_LEAD;
        w_cnt_nxt   = '0;
        w_rti_nxt   = 1'b1;
      end
      H_LEAD: begin
        if (r_cnt == w_lead_last) begin
          w_state_nxt = H_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LEN_ONE;
        end
      end
      H_SHIFT: begin
        if (r_cnt == r_len - LEN_ONE) begin
          w_state_nxt = H_TAIL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LEN_ONE;
        end
      end
      H_TAIL: begin
        if (r_cnt == LEN_ONE) begin
          w_state_nxt = H_IDLE;
          w_rti_nxt   = 1'b1;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LEN_ONE;
        end
      end
      H_RUN: begin
        if (r_cnt == r_len - LEN_ONE) begin
          w_state_nxt = H_IDLE;
          w_rti_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LEN_ONE;
        end
      end
      default: w_state_nxt = H_IDLE;
    endcase
  end

  // Pins are decoded from the next state so they change together with the FSM, one cycle ahead of the TAP edge.
  always_comb begin
    w_tms_nxt = 1'b0;
    w_tdi_nxt = 1'b0;
    case (w_state_nxt)
      H_IDLE:  w_tms_nxt = !w_rti_nxt;
      H_RESET: w_tms_nxt = (w_cnt_nxt != RST_LAST);
      H_LEAD:  w_tms_nxt = (w_op_nxt == OP_IR) ? (w_cnt_nxt < LEN_W'(2)) : (w_cnt_nxt == '0);
      H_SHIFT: begin
        w_tms_nxt = (w_cnt_nxt == w_len_nxt - LEN_ONE);
        w_tdi_nxt = w_data_nxt[w_cnt_nxt[IDX_W-1:0]];
      end
      H_TAIL:  w_tms_nxt = (w_cnt_nxt == '0);
      default: ;
    endcase
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      r_state     <= H_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_RESET;
      r_len       <= LEN_ONE;
      r_data      <= '0;
      r_rti       <= 1'b0;
      r_cap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_rti   <= w_rti_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
      // The TAP shifts on the same edge that ends our shift cycle, so TDO here is bit r_cnt.
      if (w_accept)
        r_cap <= '0;
      else if (r_state == H_SHIFT)
        r_cap[r_cnt[IDX_W-1:0]] <= tap_tdo;
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_cap;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - self-checking bench for jtag_host with a paired 1149.1 TAP
// A sequence-list model predicts pins and handshakes every cycle; directed vectors pin latencies and results.
module tb_jtag_host;

  logic        tclk = 1'b0;
  logic        trst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic        tap_tms;
  logic        tap_tdi;
  logic        tap_tdo = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  jtag_host #(.DATA_W(32), .LEN_W(6)) dut (
    .tclk(tclk), .trst(trst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .tap_tms(tap_tms), .tap_tdi(tap_tdi), .tap_tdo(tap_tdo)
  );

  always #5 tclk = ~tclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- paired TAP (IR 4 bits, IDCODE opcode 4'hE, anything else is BYPASS)
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_st_t;

  localparam logic [3:0]  IDC    = 4'hE;
  localparam logic [31:0] IDCODE = 32'h1BEEF002;

  tap_st_t     ts = T_TLR;
  logic [3:0]  ir = IDC;
  logic [3:0]  irs = 4'd0;
  logic [31:0] idr = 32'd0;
  logic        bp = 1'b0;

  function automatic tap_st_t tap_next(input tap_st_t s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  always @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ts <= T_TLR; ir <= IDC; irs <= 4'd0; idr <= 32'd0; bp <= 1'b0;
    end else begin
      case (ts)
        T_TLR:  ir <= IDC;
        T_CDR:  begin idr <= IDCODE; bp <= 1'b0; end
        T_SHDR: if (ir == IDC) idr <= {tap_tdi, idr[31:1]}; else bp <= tap_tdi;
        T_CIR:  irs <= 4'b0001;
        T_SHIR: irs <= {tap_tdi, irs[3:1]};
        T_UIR:  ir <= irs;
        default: ;
      endcase
      ts <= tap_next(ts, tap_tms);
    end
  end

  always @(negedge tclk)
    tap_tdo <= (ts == T_SHDR) ? ((ir == IDC) ? idr[0] : bp) : (ts == T_SHIR) ? irs[0] : 1'b0;

  // ---------------- behavioural model: list of {tms,tdi} cycles still to be driven
  logic [1:0]  mq[$];
  bit          m_rti = 1'b0;
  bit          m_rv = 1'b0;
  logic [31:0] m_rd = 32'd0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_d = 32'd0;
  logic [31:0] drv_exp = 32'd0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_cnt = 0;

  always @(posedge tclk or negedge trst) begin
    int n;
    bit ready_pre;
    if (!trst) begin
      mq.delete(); m_rti = 1'b0; m_rv = 1'b0; m_rd = 32'd0; m_pend = 1'b0;
    end else begin
      cyc++;
      ready_pre = (mq.size() == 0) && !m_rv;
      if (m_rv && rsp_ready) m_rv = 1'b0;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_rti = 1'b1;
          if (m_pend) begin m_rv = 1'b1; m_rd = m_pend_d; m_pend = 1'b0; end
        end
      end
      if (ready_pre && cmd_valid) begin
        n = (cmd_len == 6'd0) ? 1 : (cmd_len > 6'd32) ? 32 : int'(cmd_len);
        if (cmd_op == 2'd0) begin
          for (int i = 0; i < 6; i++) mq.push_back({(i != 5), 1'b0});
        end else begin
          if (!m_rti) mq.push_back(2'b00);
          if (cmd_op == 2'd3) begin
            for (int i = 0; i < n; i++) mq.push_back(2'b00);
          end else begin
            if (cmd_op == 2'd1) begin mq.push_back(2'b10); mq.push_back(2'b10); end
            else mq.push_back(2'b10);
            mq.push_back(2'b00); mq.push_back(2'b00);
            for (int i = 0; i < n; i++) mq.push_back({(i == n - 1), cmd_data[i]});
            mq.push_back(2'b10); mq.push_back(2'b00);
            m_pend = 1'b1; m_pend_d = drv_exp;
          end
        end
        acc_cyc = cyc;
        acc_cnt++;
      end
    end
  end

  always @(negedge tclk) begin
    logic e_tms, e_tdi, e_busy, e_rdy;
    if (mq.size() != 0) begin
      e_tms = mq[0][1]; e_tdi = mq[0][0]; e_busy = 1'b1; e_rdy = 1'b0;
    end else begin
      e_tms = !m_rti; e_tdi = 1'b0; e_busy = 1'b0; e_rdy = !m_rv;
    end
    chk("cyc_tms", 32'(tap_tms), 32'(e_tms));
    chk("cyc_tdi", 32'(tap_tdi), 32'(e_tdi));
    chk("cyc_busy", 32'(busy), 32'(e_busy));
    chk("cyc_cmd_ready", 32'(cmd_ready), 32'(e_rdy));
    chk("cyc_rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("cyc_rsp_data", rsp_data, m_rd);
  end

  // ---------------- directed stimulus
  task automatic wait_acc(input int a0, input string nm);
    int t = 0;
    while (acc_cnt == a0 && t < 200) begin @(negedge tclk); t++; end
    chk({nm, "_accept"}, 32'(acc_cnt != a0), 32'd1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                        input int exp_busy, input logic [31:0] exp_rsp, input int hold, input string nm);
    int a0, bc;
    logic [63:0] tseq;
    @(negedge tclk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data; drv_exp = exp_rsp;
    a0 = acc_cnt;
    wait_acc(a0, nm);
    cmd_valid = 1'b0; cmd_data = ~data; cmd_len = 6'(~len); cmd_op = 2'(~op);
    bc = 0; tseq = 64'd0;
    while (busy && bc < 100) begin
      tseq = {tseq[62:0], tap_tms};
      bc++;
      @(negedge tclk);
    end
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    if (op == 2'd0) chk({nm, "_tms_seq"}, 32'(tseq[5:0]), 32'b111110);
    if (op == 2'd1 || op == 2'd2) begin
      chk({nm, "_rsp_valid_at_end"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_rsp_data"}, rsp_data, exp_rsp);
      if (hold > 0) begin
        repeat (hold) @(negedge tclk);
        chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_hold_data"}, rsp_data, exp_rsp);
        chk({nm, "_hold_ready"}, 32'(cmd_ready), 32'd0);
        chk({nm, "_hold_tms"}, 32'(tap_tms), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge tclk);
      rsp_ready = 1'b0;
      chk({nm, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
      chk({nm, "_ready_back"}, 32'(cmd_ready), 32'd1);
    end else begin
      chk({nm, "_no_rsp"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int a0;
    #12;
    chk("rst_tms", 32'(tap_tms), 32'd1);
    chk("rst_tdi", 32'(tap_tdi), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #10 trst = 1'b1;
    repeat (3) @(negedge tclk);

    do_cmd(2'd0, 6'd0,  32'h0,  6,  32'h0,        0,  "reset");
    do_cmd(2'd2, 6'd32, 32'h0,  37, 32'h1BEEF002, 0,  "idcode");
    do_cmd(2'd1, 6'd6,  32'h0,  12, 32'h01,       0,  "ir_capture");
    do_cmd(2'd2, 6'd8,  32'hA5, 13, 32'h4A,       10, "bypass8");
    do_cmd(2'd2, 6'd1,  32'h1,  6,  32'h0,        0,  "bypass1");
    do_cmd(2'd3, 6'd0,  32'h0,  1,  32'h0,        0,  "idle0");
    do_cmd(2'd3, 6'd40, 32'h0,  32, 32'h0,        0,  "idle40");

    // DR scan cut short by trst while shift bit 10 is on the pins
    @(negedge tclk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = 32'hDEADBEEF; drv_exp = 32'h0;
    a0 = acc_cnt;
    wait_acc(a0, "midrst");
    cmd_valid = 1'b0;
    repeat (13) @(negedge tclk);
    chk("midrst_tdi_bit10", 32'(tap_tdi), 32'd1);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 trst = 1'b0;
    #1;
    chk("midrst_tms", 32'(tap_tms), 32'd1);
    chk("midrst_tdi", 32'(tap_tdi), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge tclk);
    #2 trst = 1'b1;
    repeat (3) @(negedge tclk);
    do_cmd(2'd2, 6'd32, 32'hFFFFFFFF, 38, 32'h1BEEF002, 0, "idcode_pre");
    repeat (3) @(negedge tclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
